// File: rtl/scs_decoder_rx.sv
// scs_decoder_rx: undoes 32-bit bus-invert coding and buffers decoded payloads
// in a 2-entry elastic stage, keeping saturating link statistics.
module scs_decoder_rx #(
    parameter int FLIT_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [FLIT_W-2:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              last_inv,
    input  logic              stat_clr,
    output logic [CNT_W-1:0]  flit_cnt,
    output logic [CNT_W-1:0]  inv_cnt
);
    localparam int PW = FLIT_W - 1;

    logic [PW-1:0]    mem_q [2];
    logic [1:0]       occ_q, occ_d;
    logic             rd_q, rd_d, wr_q, wr_d;
    logic             last_inv_q, last_inv_d;
    logic [CNT_W-1:0] flit_q, flit_d, inv_q, inv_d;
    logic             push, pop, flag;
    logic [PW-1:0]    payload;

    // Readiness comes only from registered occupancy, so out_ready never reaches in_ready.
    assign in_ready  = occ_q != 2'd2;
    assign out_valid = occ_q != 2'd0;
    assign out_data  = mem_q[rd_q];
    assign last_inv  = last_inv_q;
    assign flit_cnt  = flit_q;
    assign inv_cnt   = inv_q;
    assign flag      = in_data[FLIT_W-1];
    assign payload   = in_data[PW-1:0] ^ {PW{flag}};
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        occ_d      = occ_q + 2'(push) - 2'(pop);
        rd_d       = rd_q ^ pop;
        wr_d       = wr_q ^ push;
        last_inv_d = push ? flag : last_inv_q;
        flit_d     = stat_clr ? '0 : (push && flit_q != '1) ? flit_q + CNT_W'(1) : flit_q;
        inv_d      = stat_clr ? '0 : (push && flag && inv_q != '1) ? inv_q + CNT_W'(1) : inv_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q      <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            last_inv_q <= 1'b0;
            flit_q     <= '0;
            inv_q      <= '0;
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
        end else begin
            occ_q      <= occ_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            last_inv_q <= last_inv_d;
            flit_q     <= flit_d;
            inv_q      <= inv_d;
            if (push) mem_q[wr_q] <= payload;
        end
    end
endmodule

// File: tb/tb_scs_decoder_rx.sv
// tb_scs_decoder_rx: directed and scoreboarded checks of the bus-invert decoder
// and its 2-entry elastic buffer.
module tb_scs_decoder_rx;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready, last_inv, stat_clr;
    logic [31:0] in_data;
    logic [30:0] out_data;
    logic [15:0] flit_cnt, inv_cnt;
    int          errors = 0, checks = 0;

    scs_decoder_rx dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .last_inv(last_inv), .stat_clr(stat_clr), .flit_cnt(flit_cnt), .inv_cnt(inv_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] encode(input logic [30:0] x, input logic f);
        return {f, f ? ~x : x};
    endfunction

    initial begin
        logic [30:0] xs [100];
        logic [30:0] q [$];
        logic [30:0] held, exp_d;
        logic        f, stalled;
        int          nflags, mism, drops, bad_stable, bad_order, budget;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; stat_clr = 1'b0; in_data = '0;
        tick(); tick();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_last_inv", 32'(last_inv), 0);
        chk("rst_flit_cnt", 32'(flit_cnt), 0);
        chk("rst_inv_cnt", 32'(inv_cnt), 0);
        rst = 1'b0;

        // all-ones payload sent inverted
        in_data = 32'h8000_0000; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t1_out_valid", 32'(out_valid), 1);
        chk("t1_out_data", 32'(out_data), 32'h7FFF_FFFF);
        chk("t1_last_inv", 32'(last_inv), 1);
        chk("t1_flit_cnt", 32'(flit_cnt), 1);
        chk("t1_inv_cnt", 32'(inv_cnt), 1);
        tick();
        chk("t1_drained", 32'(out_valid), 0);

        // fill both entries while stalled
        out_ready = 1'b0;
        in_data = 32'h1234_5678; in_valid = 1'b1;
        tick();
        chk("t2_ready_after_1", 32'(in_ready), 1);
        in_data = 32'hEDCB_A987;
        tick();
        in_valid = 1'b0;
        chk("t2_full", 32'(in_ready), 0);
        chk("t2_first", 32'(out_data), 32'h1234_5678);
        chk("t2_flit_cnt", 32'(flit_cnt), 3);
        chk("t2_inv_cnt", 32'(inv_cnt), 2);
        tick();
        chk("t2_stall_stable", 32'(out_data), 32'h1234_5678);
        chk("t2_stall_full", 32'(in_ready), 0);
        out_ready = 1'b1;
        tick();
        chk("t2_ready_after_pop", 32'(in_ready), 1);
        chk("t2_second_valid", 32'(out_valid), 1);
        chk("t2_second", 32'(out_data), 32'h1234_5678);
        chk("t2_last_inv", 32'(last_inv), 1);
        tick();
        chk("t2_empty", 32'(out_valid), 0);

        // back-to-back stream, counters cleared first
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        nflags = 0; mism = 0; drops = 0;
        for (int i = 0; i < 100; i++) begin
            xs[i] = 31'($urandom);
            f = 1'($urandom);
            nflags += int'(f);
            if (!in_ready) drops++;
            in_data = encode(xs[i], f); in_valid = 1'b1;
            tick();
            if (!out_valid || out_data !== xs[i]) mism++;
        end
        in_valid = 1'b0;
        chk("t3_data_mismatches", 32'(mism), 0);
        chk("t3_in_ready_drops", 32'(drops), 0);
        chk("t3_flit_cnt", 32'(flit_cnt), 100);
        chk("t3_inv_cnt", 32'(inv_cnt), 32'(nflags));
        tick();

        // random handshakes against a scoreboard
        bad_stable = 0; bad_order = 0;
        in_valid = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            if (!(in_valid && !in_ready)) begin
                in_valid = 1'($urandom);
                in_data = encode(31'($urandom), 1'($urandom));
            end
            out_ready = 1'($urandom);
            #1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) bad_order++;
                else begin
                    exp_d = q.pop_front();
                    if (out_data !== exp_d) bad_order++;
                end
            end
            if (in_valid && in_ready)
                q.push_back(in_data[30:0] ^ {31{in_data[31]}});
            stalled = out_valid && !out_ready;
            held = out_data;
            tick();
            if (stalled && out_data !== held) bad_stable++;
        end
        in_valid = 1'b0; out_ready = 1'b1; budget = 0;
        #1;
        while (out_valid && budget < 10) begin
            if (q.size() == 0) bad_order++;
            else begin
                exp_d = q.pop_front();
                if (out_data !== exp_d) bad_order++;
            end
            tick();
            budget++;
            #1;
        end
        chk("t4_order", 32'(bad_order), 0);
        chk("t4_stable", 32'(bad_stable), 0);
        chk("t4_leftover", 32'(q.size()), 0);
        chk("t4_drained", 32'(out_valid), 0);

        // counter saturation, then clear colliding with a push
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        in_data = 32'h0000_0001; in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 65534; i++) tick();
        chk("t5_preload", 32'(flit_cnt), 32'hFFFE);
        tick();
        chk("t5_reach_max", 32'(flit_cnt), 32'hFFFF);
        tick(); tick();
        chk("t5_hold_max", 32'(flit_cnt), 32'hFFFF);
        in_data = 32'h8000_0001; stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0; in_valid = 1'b0;
        chk("t5_clr_flit", 32'(flit_cnt), 0);
        chk("t5_clr_inv", 32'(inv_cnt), 0);
        chk("t5_clr_buffer_kept", 32'(out_data), 32'h7FFF_FFFE);
        tick();
        chk("t5_clr_stays", 32'(flit_cnt), 0);

        // reset with a full buffer and a pending flit
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 32'h0000_00AA;
        tick();
        in_data = 32'h8000_0055;
        tick();
        chk("t6_full", 32'(in_ready), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        chk("t6_out_valid", 32'(out_valid), 0);
        chk("t6_in_ready", 32'(in_ready), 1);
        chk("t6_flit_cnt", 32'(flit_cnt), 0);
        chk("t6_inv_cnt", 32'(inv_cnt), 0);
        chk("t6_last_inv", 32'(last_inv), 0);
        // a push offered while reset is asserted is dropped
        rst = 1'b1; in_valid = 1'b1; in_data = 32'h8000_0000;
        tick();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("t6_push_in_rst_dropped", 32'(out_valid), 0);
        chk("t6_push_in_rst_uncounted", 32'(flit_cnt), 0);
        tick();
        chk("t6_nothing_delivered", 32'(out_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
